// File: rtl/demux_deserializer.sv
// demux_deserializer: per-channel LSB-first deserializer behind a 1-to-4 demux, round-robin valid/ready output.
// Define DEMUX_CHECK_EN to drop bits whose non-selected demux lines are active and raise sticky err_o.
module demux_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    input  logic [1:0]       sel_i,
    input  logic [3:0]       a_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       out_ch_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic [3:0]       overflow_o,
    output logic             err_o
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] sh_q [4];
    logic [WIDTH-1:0] sh_d [4];
    logic [WIDTH-1:0] hold_q [4];
    logic [WIDTH-1:0] hold_d [4];
    logic [CW-1:0]    cnt_q [4];
    logic [CW-1:0]    cnt_d [4];
    logic [3:0]       pend_q, pend_d, ovf_q, ovf_d, clr;
    logic [1:0]       rr_q, gnt, idx;
    logic             found, load, bad, acc, done;
    logic [WIDTH-1:0] word;
    logic             out_valid_q;
    logic [1:0]       out_ch_q;
    logic [WIDTH-1:0] out_data_q;
`ifdef DEMUX_CHECK_EN
    logic err_q;
    assign bad = in_valid_i & |(a_i & ~(4'b0001 << sel_i));
    always_ff @(posedge clk_i) err_q <= !rst_n_i ? 1'b0 : (err_q | bad);
    assign err_o = err_q;
`else
    assign bad = 1'b0;
    assign err_o = 1'b0;
`endif
    assign acc  = in_valid_i & ~bad;
    assign word = {a_i[sel_i], sh_q[sel_i][WIDTH-1:1]};
    assign done = acc && (cnt_q[sel_i] == CW'(WIDTH - 1));
    assign load = !out_valid_q || out_ready_i;
    // Round-robin search starts one past the last granted channel.
    always_comb begin
        gnt   = rr_q;
        found = 1'b0;
        idx   = rr_q;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && pend_q[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
        clr = (load && found) ? (4'b0001 << gnt) : 4'b0000;
    end
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        pend_d = pend_q & ~clr;
        ovf_d  = ovf_q;
        if (acc) begin
            sh_d[sel_i]  = word;
            cnt_d[sel_i] = done ? '0 : cnt_q[sel_i] + 1'b1;
            // A pend being drained this very cycle frees the hold slot for the new word.
            if (done && pend_q[sel_i] && !clr[sel_i]) begin
                ovf_d[sel_i] = 1'b1;
            end else if (done) begin
                hold_d[sel_i] = word;
                pend_d[sel_i] = 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sh_q        <= '{default: '0};
            cnt_q       <= '{default: '0};
            hold_q      <= '{default: '0};
            pend_q      <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            rr_q        <= 2'd3;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            if (load) begin
                out_valid_q <= found;
                if (found) begin
                    out_ch_q   <= gnt;
                    out_data_q <= hold_q[gnt];
                    rr_q       <= gnt;
                end
            end
        end
    end
    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;
    assign out_data_o  = out_data_q;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_demux_deserializer.sv
// tb_demux_deserializer: directed tests of demux_deserializer (WIDTH=8) with hand-computed expectations.
module tb_demux_deserializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] a = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_ch;
    logic [7:0] out_data;
    logic [3:0] overflow;
    logic       err;
    int         passed = 0;
    int         total = 0;

    demux_deserializer #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .sel_i(sel), .a_i(a),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch),
        .out_data_o(out_data), .overflow_o(overflow), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] ch, input logic b);
        sel      = ch;
        a        = {3'b000, b} << ch;
        in_valid = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [1:0] ch, input logic [7:0] w);
        for (int i = 0; i < 8; i++) strobe(ch, w[i]);
        in_valid = 1'b0;
        a        = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({out_valid, out_ch, out_data, overflow, err} !== 16'h0)
            $display("FAIL reset_state got v=%b ch=%0d d=%h ovf=%b err=%b exp all zero", out_valid, out_ch, out_data, overflow, err);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send_word(2'd1, 8'h4D);
        total++;
        if (out_valid !== 1'b0) $display("FAIL single_latency got v=%b exp 0", out_valid);
        else passed++;
        tick();
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h4D})
            $display("FAIL single_word got v=%b ch=%0d d=%h exp v=1 ch=1 d=4d", out_valid, out_ch, out_data);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL single_drop got v=%b exp 0", out_valid);
        else passed++;
    endtask

    task automatic test_order();
        out_ready = 1'b0;
        send_word(2'd3, 8'h11);
        send_word(2'd0, 8'h22);
        send_word(2'd2, 8'h33);
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'h11})
            $display("FAIL order_first got v=%b ch=%0d d=%h exp v=1 ch=3 d=11", out_valid, out_ch, out_data);
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'h22})
            $display("FAIL order_second got v=%b ch=%0d d=%h exp v=1 ch=0 d=22", out_valid, out_ch, out_data);
        else passed++;
        tick();
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'h33})
            $display("FAIL order_third got v=%b ch=%0d d=%h exp v=1 ch=2 d=33", out_valid, out_ch, out_data);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL order_empty got v=%b exp 0", out_valid);
        else passed++;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_word(2'd0, 8'hA5);
        send_word(2'd0, 8'h3C);
        total++;
        if (overflow !== 4'b0000) $display("FAIL ovf_before got %b exp 0000", overflow);
        else passed++;
        send_word(2'd0, 8'hFF);
        total++;
        if ({overflow, out_valid, out_ch, out_data} !== {4'b0001, 1'b1, 2'd0, 8'hA5})
            $display("FAIL ovf_set got ovf=%b v=%b ch=%0d d=%h exp ovf=0001 v=1 ch=0 d=a5", overflow, out_valid, out_ch, out_data);
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'h3C})
            $display("FAIL ovf_second got v=%b ch=%0d d=%h exp v=1 ch=0 d=3c", out_valid, out_ch, out_data);
        else passed++;
        tick();
        total++;
        if ({out_valid, overflow} !== {1'b0, 4'b0001})
            $display("FAIL ovf_dropped got v=%b ovf=%b exp v=0 ovf=0001", out_valid, overflow);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        w = 8'h0F;
        out_ready = 1'b0;
        send_word(2'd1, 8'h5A);
        tick();
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h5A})
            $display("FAIL bp_load got v=%b ch=%0d d=%h exp v=1 ch=1 d=5a", out_valid, out_ch, out_data);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            strobe(2'd2, w[i]);
            total++;
            if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h5A})
                $display("FAIL bp_hold%0d got v=%b ch=%0d d=%h exp v=1 ch=1 d=5a", i, out_valid, out_ch, out_data);
            else passed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'h0F})
            $display("FAIL bp_next got v=%b ch=%0d d=%h exp v=1 ch=2 d=0f", out_valid, out_ch, out_data);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL bp_empty got v=%b exp 0", out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_word();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) strobe(2'd2, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        total++;
        if ({out_valid, out_ch, out_data, overflow, err} !== 16'h0)
            $display("FAIL rst_mid_outputs got v=%b ch=%0d d=%h ovf=%b err=%b exp all zero", out_valid, out_ch, out_data, overflow, err);
        else passed++;
        rst_n = 1'b1;
        send_word(2'd2, 8'h81);
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_early got v=%b exp 0", out_valid);
        else passed++;
        tick();
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'h81})
            $display("FAIL rst_mid_word got v=%b ch=%0d d=%h exp v=1 ch=2 d=81", out_valid, out_ch, out_data);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_single got v=%b exp 0", out_valid);
        else passed++;
    endtask

    task automatic test_clear_same_cycle();
        logic [7:0] w;
        w = 8'hC3;
        out_ready = 1'b0;
        send_word(2'd0, 8'h01);
        send_word(2'd0, 8'h02);
        for (int i = 0; i < 7; i++) strobe(2'd0, w[i]);
        out_ready = 1'b1;
        strobe(2'd0, w[7]);
        in_valid = 1'b0;
        total++;
        if ({overflow, out_valid, out_ch, out_data} !== {4'b0000, 1'b1, 2'd0, 8'h02})
            $display("FAIL clr_same got ovf=%b v=%b ch=%0d d=%h exp ovf=0000 v=1 ch=0 d=02", overflow, out_valid, out_ch, out_data);
        else passed++;
        tick();
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'hC3})
            $display("FAIL clr_new got v=%b ch=%0d d=%h exp v=1 ch=0 d=c3", out_valid, out_ch, out_data);
        else passed++;
        tick();
    endtask

    task automatic test_check();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sel       = 2'd0;
        a         = 4'b0110;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = '0;
`ifdef DEMUX_CHECK_EN
        total++;
        if (err !== 1'b1) $display("FAIL check_err got %b exp 1", err);
        else passed++;
        send_word(2'd0, 8'hFF);
        tick();
        total++;
        if ({out_valid, out_ch, out_data, err} !== {1'b1, 2'd0, 8'hFF, 1'b1})
            $display("FAIL check_discard got v=%b ch=%0d d=%h err=%b exp v=1 ch=0 d=ff err=1", out_valid, out_ch, out_data, err);
        else passed++;
`else
        total++;
        if (err !== 1'b0) $display("FAIL check_err got %b exp 0", err);
        else passed++;
        for (int i = 1; i < 8; i++) strobe(2'd0, 1'b1);
        in_valid = 1'b0;
        tick();
        total++;
        if ({out_valid, out_ch, out_data, err} !== {1'b1, 2'd0, 8'hFE, 1'b0})
            $display("FAIL check_shift got v=%b ch=%0d d=%h err=%b exp v=1 ch=0 d=fe err=0", out_valid, out_ch, out_data, err);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_overflow();
        test_backpressure();
        test_reset_mid_word();
        test_clear_same_cycle();
        test_check();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/demux_deserializer.md
# demux_deserializer

Per-channel deserializer downstream of the 1-to-4 bit demultiplexer. Consumes the demux's 4-bit output and select code under a valid strobe, assembles each channel's bit stream into WIDTH-bit words in per-channel shift registers, and presents completed words on a single valid/ready output port. Output arbitration is round-robin, with a per-channel sticky overflow flag.

## Interface
- WIDTH, 8, bits per assembled word (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  demux output valid this cycle
- sel  input  2  demux select code; channel the bit belongs to
- a  input  4  demux outputs; a[sel] carries the data bit
- out_valid  output  1  out_ch/out_data hold a word
- out_ready  input  1  consumer accepts word
- out_ch  output  2  channel of presented word
- out_data  output  WIDTH  assembled word, first-received bit in bit 0
- overflow  output  4  sticky per-channel word-drop flags
- err  output  1  sticky select/data consistency error (DEMUX_CHECK_EN only)

## Operation
- Per channel c: shift register sh[c] (WIDTH), bit counter cnt[c] (0..WIDTH-1), hold register hold[c], flag pend[c].
- Accept: in_valid=1 → bit b=a[sel]; sh[sel] <= {b, sh[sel][WIDTH-1:1]} (LSB-first); cnt[sel]++.
- Completion: accepted bit with cnt[sel]==WIDTH-1 → cnt wraps to 0; completed word {b, sh[WIDTH-1:1]} goes to hold[sel], pend[sel] set.
- Overflow: completion while pend[sel]=1 and not being cleared this cycle → word dropped, hold unchanged, overflow[sel] set. Cleared only by reset.
- Completion on a channel whose pend is cleared in the same cycle → new word accepted, no overflow.
- Output register loads when out_valid=0 or (out_valid & out_ready). It takes the first pending channel searching rr+1, rr+2, rr+3, rr (mod 4), clears that pend bit, and sets rr to that channel. With none pending, out_valid drops to 0.
- Words reach the output register only through pend; a completion and its load are never the same cycle.
- Non-selected channels are unaffected by any strobe.

## Timing
- Reset (rst_n=0 at edge): sh, cnt, hold, pend, out_data, out_ch, overflow, err all 0; out_valid=0; rr=3, so ch0 has first priority. Partial words are discarded.
- Latency: last bit strobed at edge N → pend set at N → out_valid=1 after edge N+1 if the output register is free.
- Throughput: one word per cycle at the output; one bit per cycle at the input.
- Backpressure: while out_valid & !out_ready, out_valid, out_ch and out_data hold stable.
- Handshake completes on an edge with out_valid & out_ready. The next pending word is presented from that same edge, with no bubble.
- in_valid is sampled every cycle regardless of output state. Input has no backpressure; loss is reported via overflow.

## Configuration
- DEMUX_CHECK_EN defined: when in_valid=1 and any a bit other than a[sel] is 1, the bit is discarded (sh and cnt unchanged) and err is set (sticky until reset).
- DEMUX_CHECK_EN undefined: a[sel] is used unconditionally, and err is tied to 0.

## Test plan
- WIDTH=8, out_ready=1: strobe ch1 with bits 1,0,1,1,0,0,1,0 → one cycle after the last strobe, out_valid=1, out_ch=1, out_data=8'h4D, held one cycle.
- out_ready=0: complete ch3, then ch0, then ch2 → out_ch=3 first; raise out_ready → subsequent out_ch 0 then 2, out_data matching each stream.
- out_ready=0: complete ch0 words 8'hA5, 8'h3C, 8'hFF → overflow=4'b0001 after the third; with ready, the outputs are 8'hA5 then 8'h3C, and 8'hFF is never presented.
- out_valid=1 with out_ready=0 for 5 cycles while other channels complete → out_data/out_ch unchanged throughout.
- Strobe 5 bits on ch2, pulse rst_n=0 one cycle, then strobe 8'h81 pattern on ch2 → exactly one word 8'h81 is presented on ch2; all outputs are 0 during reset.
- DEMUX_CHECK_EN: in_valid=1, sel=0, a=4'b0110 → err=1 next cycle, cnt[0] unchanged. Without the macro, the same stimulus shifts bit 0 into ch0 and err stays 0.
